// File: rtl/dac_update_scheduler_if.sv
// Bundle between the sequencer channels, the update scheduler and the
// MCP4725 DAC controller. The scheduler uses the slave view; the
// surrounding logic (or a bench) uses the master view.
interface dac_update_scheduler_if #(
  parameter int N_CH = 4
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // channel side
  logic [N_CH-1:0]      req;
  logic [12*N_CH-1:0]   req_data;
  logic [2*N_CH-1:0]    req_mode;
  logic [N_CH-1:0]      ack;
  logic                 err;
  // DAC controller side
  logic [11:0]          dac_data;
  logic [1:0]           dac_mode;
  logic                 dac_enable;
  logic                 dac_busy;
  // status
  logic [CW-1:0]        active_ch;
  logic                 idle;

  modport slave (
    input  req, req_data, req_mode, dac_busy,
    output ack, err, dac_data, dac_mode, dac_enable, active_ch, idle
  );

  modport master (
    output req, req_data, req_mode, dac_busy,
    input  ack, err, dac_data, dac_mode, dac_enable, active_ch, idle
  );
endinterface

// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler sharing one MCP4725 DAC controller between N_CH
// sequencer channels. Grants a channel, holds dac_enable until the I2C
// engine reports busy, waits for completion, acks the channel and then
// enforces a hold-off before the next grant.
// Optional build macro: DAC_WATCHDOG_EN -- aborts a transaction whose
// dac_busy stays high for WD_CYCLES cycles (err + ack pulse together).
module dac_update_scheduler #(
  parameter int N_CH          = 4,
  parameter int START_TIMEOUT = 64,
  parameter int HOLDOFF       = 16,
  parameter int WD_CYCLES     = 65535
)(
  input  logic clk,
  input  logic rst,
  dac_update_scheduler_if.slave bus
);

  localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  // one shared counter covers start timeout, hold-off and watchdog
  localparam int CNT_MAX = (START_TIMEOUT > HOLDOFF)
                           ? ((START_TIMEOUT > WD_CYCLES) ? START_TIMEOUT : WD_CYCLES)
                           : ((HOLDOFF > WD_CYCLES) ? HOLDOFF : WD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(START_TIMEOUT - 1);
  // HOLDOFF=0 still spends the entry cycle in HOLDOFF before IDLE
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
`ifdef DAC_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT_START, S_WAIT_DONE, S_HOLDOFF
  } state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CW-1:0]     r_rr, r_active, w_gnt;
  logic              w_gnt_vld;
  logic [N_CH-1:0]   r_ack, w_ack_vec;
  logic              r_err, w_abort, w_ack_set, w_enable_nxt;
  logic [11:0]       r_dac_data;
  logic [1:0]        r_dac_mode;
  logic              r_enable;

  // round-robin search: first requester after r_rr, wrapping; descending
  // loop so the nearest candidate is written last and wins
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(r_rr) + k) % N_CH;
      if (bus.req[idx]) begin
        w_gnt     = CW'(idx);
        w_gnt_vld = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_gnt_vld) w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (bus.dac_busy)          w_next = S_WAIT_DONE;
        else if (r_cnt == ST_LAST) w_next = S_HOLDOFF;
      end
      S_WAIT_DONE: begin
        if (!bus.dac_busy)         w_next = S_HOLDOFF;
`ifdef DAC_WATCHDOG_EN
        else if (r_cnt == WD_LAST) w_next = S_HOLDOFF;
`endif
      end
      S_HOLDOFF:    if (r_cnt == HO_LAST) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // output decode: which registered pulses/levels fire on this edge
  always_comb begin
`ifdef DAC_WATCHDOG_EN
    w_abort = (r_state == S_WAIT_DONE) && bus.dac_busy && (r_cnt == WD_LAST);
`else
    w_abort = 1'b0;
`endif
    // start timeout means the DAC already held the value: still an ack
    w_ack_set    = ((r_state == S_WAIT_START) && !bus.dac_busy && (r_cnt == ST_LAST)) ||
                   ((r_state == S_WAIT_DONE)  && !bus.dac_busy) ||
                   w_abort;
    w_ack_vec    = w_ack_set ? (N_CH'(1) << r_active) : '0;
    w_enable_nxt = (w_next == S_WAIT_START);
  end

  // datapath: grant capture, counter, registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rr       <= CW'(N_CH - 1);
      r_active   <= '0;
      r_dac_data <= '0;
      r_dac_mode <= '0;
      r_enable   <= 1'b0;
      r_ack      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cnt    <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + CNT_W'(1);
      r_enable <= w_enable_nxt;
      r_ack    <= w_ack_vec;
      r_err    <= w_abort;
      if (r_state == S_IDLE && w_gnt_vld) begin
        r_rr       <= w_gnt;
        r_active   <= w_gnt;
        r_dac_data <= bus.req_data[12*int'(w_gnt) +: 12];
        r_dac_mode <= bus.req_mode[2*int'(w_gnt) +: 2];
      end
    end
  end

  assign bus.ack        = r_ack;
  assign bus.err        = r_err;
  assign bus.dac_data   = r_dac_data;
  assign bus.dac_mode   = r_dac_mode;
  assign bus.dac_enable = r_enable;
  assign bus.active_ch  = r_active;
  assign bus.idle       = (r_state == S_IDLE);

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler (N_CH=4, START_TIMEOUT=64,
// HOLDOFF=16). WD_CYCLES is 100 when DAC_WATCHDOG_EN is defined.
module tb_dac_update_scheduler;
  localparam int N_CH = 4;
`ifdef DAC_WATCHDOG_EN
  localparam int WD = 100;
`else
  localparam int WD = 65535;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  dac_update_scheduler_if #(.N_CH(N_CH)) bus ();

  dac_update_scheduler #(
    .N_CH(N_CH), .START_TIMEOUT(64), .HOLDOFF(16), .WD_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [11:0] d, input logic [1:0] m);
    bus.req_data[12*ch +: 12] = d;
    bus.req_mode[2*ch +: 2]   = m;
  endtask

  // wait for grant, run a busy window of busy_len cycles, check ack and idle
  task automatic do_txn(input int exp_ch, input logic [11:0] exp_data, input int busy_len);
    int n;
    n = 0;
    while (!bus.dac_enable && n < 200) begin tick(); n++; end
    chk("enable_seen", 32'(bus.dac_enable), 32'd1);
    chk("grant_ch",    32'(bus.active_ch),  32'(exp_ch));
    chk("grant_data",  32'(bus.dac_data),   32'(exp_data));
    bus.dac_busy = 1'b1;
    tick();
    chk("enable_drop", 32'(bus.dac_enable), 32'd0);
    repeat (busy_len) tick();
    bus.dac_busy = 1'b0;
    tick();
    chk("ack_pulse",   32'(bus.ack), 32'(1 << exp_ch));
    tick();
    chk("ack_clear",   32'(bus.ack), 32'd0);
    n = 0;
    while (!bus.idle && n < 100) begin tick(); n++; end
    chk("idle_back",   32'(bus.idle), 32'd1);
  endtask

  initial begin
    int n;
    int acks;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_mode = '0;
    bus.dac_busy = 1'b0;

    // reset state
    #12;
    chk("rst_ack",    32'(bus.ack),        32'd0);
    chk("rst_err",    32'(bus.err),        32'd0);
    chk("rst_data",   32'(bus.dac_data),   32'd0);
    chk("rst_enable", 32'(bus.dac_enable), 32'd0);
    chk("rst_idle",   32'(bus.idle),       32'd1);
    chk("rst_active", 32'(bus.active_ch),  32'd0);
    rst = 1'b0;
    tick();

    // single request on channel 0, busy 2 cycles after enable for 40 cycles
    set_ch(0, 12'h800, 2'b01);
    bus.req = 4'b0001;
    tick();
    chk("t1_enable", 32'(bus.dac_enable), 32'd1);
    chk("t1_data",   32'(bus.dac_data),   32'h800);
    chk("t1_mode",   32'(bus.dac_mode),   32'd1);
    chk("t1_idle",   32'(bus.idle),       32'd0);
    tick();
    chk("t1_enable_hold", 32'(bus.dac_enable), 32'd1);
    bus.dac_busy = 1'b1;
    bus.req      = 4'b0000;
    tick();
    chk("t1_enable_drop", 32'(bus.dac_enable), 32'd0);
    acks = 0;
    repeat (39) begin tick(); if (bus.ack != 0) acks++; end
    chk("t1_no_early_ack", 32'(acks), 32'd0);
    bus.dac_busy = 1'b0;
    tick();
    chk("t1_ack", 32'(bus.ack), 32'b0001);
    chk("t1_data_held", 32'(bus.dac_data), 32'h800);
    tick();
    chk("t1_ack_clear", 32'(bus.ack), 32'd0);
    repeat (14) tick();
    chk("t1_holdoff_busy", 32'(bus.idle), 32'd0);
    tick();
    chk("t1_idle", 32'(bus.idle), 32'd1);

    // round robin with all channels requesting, from fresh reset
    rst = 1'b1; #2; rst = 1'b0;
    set_ch(0, 12'h111, 2'b00);
    set_ch(1, 12'h222, 2'b00);
    set_ch(2, 12'h333, 2'b00);
    set_ch(3, 12'h444, 2'b00);
    bus.req = 4'b1111;
    do_txn(0, 12'h111, 3);
    do_txn(1, 12'h222, 3);
    do_txn(2, 12'h333, 3);
    do_txn(3, 12'h444, 3);
    do_txn(0, 12'h111, 3);
    bus.req = 4'b0000;

    // data stability + no-change update (busy never rises) on channel 1
    set_ch(1, 12'h123, 2'b10);
    bus.req = 4'b0010;
    n = 0;
    while (!bus.dac_enable && n < 50) begin tick(); n++; end
    chk("t3_grant_ch", 32'(bus.active_ch), 32'd1);
    set_ch(1, 12'hFFF, 2'b11);
    tick();
    chk("t3_data_stable", 32'(bus.dac_data), 32'h123);
    chk("t3_mode_stable", 32'(bus.dac_mode), 32'd2);
    n = 1;
    while (bus.dac_enable && n < 200) begin n++; tick(); end
    chk("t3_enable_cycles", 32'(n), 32'd64);
    chk("t3_ack",  32'(bus.ack), 32'b0010);
    chk("t3_err",  32'(bus.err), 32'd0);
    chk("t3_holdoff", 32'(bus.idle), 32'd0);
    bus.req = 4'b0000;
    n = 0;
    while (!bus.idle && n < 100) begin tick(); n++; end
    chk("t3_idle", 32'(bus.idle), 32'd1);

    // reset in WAIT_DONE on channel 1; next grant must be channel 0, not 3
    set_ch(1, 12'h0AA, 2'b00);
    set_ch(0, 12'h0BB, 2'b00);
    bus.req = 4'b0010;
    tick();
    chk("t4_grant_ch", 32'(bus.active_ch), 32'd1);
    bus.dac_busy = 1'b1;
    tick();
    chk("t4_in_wait_done", 32'(bus.dac_enable), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_rst_enable", 32'(bus.dac_enable), 32'd0);
    chk("t4_rst_ack",    32'(bus.ack),        32'd0);
    chk("t4_rst_idle",   32'(bus.idle),       32'd1);
    chk("t4_rst_data",   32'(bus.dac_data),   32'd0);
    tick();
    rst = 1'b0;
    bus.dac_busy = 1'b0;
    bus.req = 4'b1001;
    do_txn(0, 12'h0BB, 2);
    bus.req = 4'b0000;

    // busy stuck high in WAIT_DONE on channel 2
    set_ch(2, 12'h555, 2'b00);
    bus.req = 4'b0100;
    tick();
    chk("t5_grant_ch", 32'(bus.active_ch), 32'd2);
    bus.dac_busy = 1'b1;
    tick();
`ifdef DAC_WATCHDOG_EN
    n = 0;
    while (!bus.err && n < 300) begin tick(); n++; end
    chk("t5_wd_cycles", 32'(n),        32'd100);
    chk("t5_wd_err",    32'(bus.err),  32'd1);
    chk("t5_wd_ack",    32'(bus.ack),  32'b0100);
    tick();
    chk("t5_err_clear", 32'(bus.err),  32'd0);
    chk("t5_holdoff",   32'(bus.idle), 32'd0);
    bus.dac_busy = 1'b0;
    bus.req = 4'b0000;
    n = 0;
    while (!bus.idle && n < 100) begin tick(); n++; end
    chk("t5_idle", 32'(bus.idle), 32'd1);
`else
    acks = 0;
    repeat (1000) begin tick(); if (bus.err || bus.ack != 0) acks++; end
    chk("t5_no_wd_pulse", 32'(acks), 32'd0);
    bus.dac_busy = 1'b0;
    bus.req = 4'b0000;
    tick();
    chk("t5_ack_late", 32'(bus.ack), 32'b0100);
    chk("t5_err_tied", 32'(bus.err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Shares the single MCP4725 DAC controller between N_CH sequencer channels (CV/pitch sources).
- Arbitrates round-robin, presents one channel's 12-bit code and 2-bit power mode to the DAC controller, and holds dac_enable until the I2C transaction starts.
- Waits for the transaction to finish, then enforces a minimum hold-off before the next update.
- Sits between the step-sequencer voice logic and the DAC controller.

Parameters:
N_CH, 4, number of requesting channels (2..8)
START_TIMEOUT, 64, clk cycles to wait for dac_busy to rise after issue
HOLDOFF, 16, idle clk cycles enforced after each completed update (0 allowed)
WD_CYCLES, 65535, watchdog limit on dac_busy high (used only with DAC_WATCHDOG_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  N_CH  per-channel update request, level; hold with data stable until ack
req_data  in  12*N_CH  channel codes, channel i at [12i+11:12i]
req_mode  in  2*N_CH  channel power-down modes, channel i at [2i+1:2i]
ack  out  N_CH  one-cycle completion pulse to the served channel
err  out  1  one-cycle pulse: transaction aborted by watchdog
dac_data  out  12  code to DAC controller
dac_mode  out  2  mode to DAC controller
dac_enable  out  1  update enable to DAC controller
dac_busy  in  1  high while the DAC controller's I2C engine is not in its ready state
active_ch  out  clog2(N_CH)  channel currently or last served
idle  out  1  high in IDLE state only

Behaviour:
- Reset values: ack=0, err=0, dac_data=0, dac_mode=0, dac_enable=0, active_ch=0, idle=1, state=IDLE, rr pointer=N_CH-1, so channel 0 has first priority.
- State IDLE:
  - If |req, grant the first requesting channel searching from rr+1 modulo N_CH.
  - Register that channel's data and mode into dac_data/dac_mode; set active_ch and rr to it.
  - Go to WAIT_START next cycle with dac_enable=1.
  - No req: stay.
- State WAIT_START:
  - dac_enable held 1; start counter counts cycles.
  - dac_busy=1: drop dac_enable next cycle, go to WAIT_DONE.
  - Counter reaches START_TIMEOUT-1 with no busy: the DAC already held this value. Drop enable, pulse ack[active_ch], go to HOLDOFF.
- State WAIT_DONE:
  - dac_enable=0.
  - dac_busy=0: pulse ack[active_ch], go to HOLDOFF.
- State HOLDOFF:
  - Count HOLDOFF cycles, then go to IDLE.
  - HOLDOFF=0: go to IDLE in the cycle after entry.
- Ack timing:
  - Exactly one ack pulse per grant, registered, asserted for one cycle.
  - Minimum latency from grant to ack is 3 cycles.
- Request rules:
  - req, data and mode are sampled only at grant; later changes do not affect the issued transaction.
  - req deasserted after grant: transaction completes and ack still pulses.
  - req deasserted before grant: no service.
- A channel that keeps req high is served again only after all other requesting channels have had a turn.
- Simultaneous ack and new req in the same cycle: the new req is considered only on return to IDLE.
- rst mid-transaction: all outputs return to reset values immediately; a DAC I2C transfer already in flight is left to finish on its own.
- Post-reset, dac_busy high while IDLE is ignored until a grant.

Optional Feature:
DAC_WATCHDOG_EN
- Defined:
  - A counter runs in WAIT_DONE.
  - If dac_busy stays 1 for WD_CYCLES cycles: pulse err and ack[active_ch] in the same cycle, then go to HOLDOFF.
- Not defined:
  - No watchdog logic; WAIT_DONE waits indefinitely.
  - err is tied to 0.

Test Plan:
- Single request: req=4'b0001, data0=12'h800, dac_busy rises 2 cycles after enable and falls 40 cycles later → dac_data=12'h800 held, enable high until busy seen, ack[0] single pulse on busy fall, idle after 16 more cycles.
- Round-robin fairness: req=4'b1111 held, each transaction completed → grant order 0,1,2,3,0; each ack exactly once per round.
- No-change update: dac_busy never rises → enable high for 64 cycles, then ack pulses, HOLDOFF entered, no err.
- Data stability: change req_data[1] from 12'h123 to 12'hFFF one cycle after grant of ch1 → dac_data stays 12'h123.
- Reset mid-transaction: assert rst in WAIT_DONE → dac_enable=0, ack=0, idle=1 same cycle; after release, next grant goes to channel 0.
- Watchdog (macro defined, WD_CYCLES=100): dac_busy stuck high → err and ack[active_ch] pulse together after 100 cycles in WAIT_DONE, then HOLDOFF; macro undefined → no pulse after 1000 cycles.
